fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares the single write port of the async FIFO (write-clock domain) among NUM_REQ requesters.
- Sits directly in front of the FIFO write-pointer/memory logic: drives its write enable and write data, and consumes its registered full flag.
- Holds a grant for a whole packet, up to MAX_BURST beats, so packets from different sources never interleave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, width of one data beat.
- MAX_BURST, 16, maximum beats per grant before forced release (≥1).
- ID_WIDTH, 2, width of source-ID output; must satisfy 2**ID_WIDTH ≥ NUM_REQ.

Ports:
- w_clk  input  1  write-domain clock.
- w_rst  input  1  reset, asynchronous, active-low.
- in_valid  input  NUM_REQ  per-requester beat valid.
- in_last  input  NUM_REQ  per-requester last beat of packet, qualified by in_valid.
- in_data  input  NUM_REQ*DATA_WIDTH  flattened beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_REQ  per-requester beat accepted this cycle.
- full  input  1  FIFO full flag, registered in w_clk domain.
- w_en  output  1  FIFO write enable.
- w_data  output  DATA_WIDTH  FIFO write data.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- cur_src  output  ID_WIDTH  binary index of current owner.
- busy  output  1  high while a grant is held.

Behaviour:
- States:
  - IDLE: no owner.
  - LOCK: owner = grant index g.
- Reset (asynchronous, w_rst low), effective immediately:
  - state=IDLE, grant=0, cur_src=0, busy=0, beat_cnt=0, rr_ptr=NUM_REQ-1.
  - in_ready=0, w_en=0, w_data=0.
- IDLE -> LOCK:
  - Taken at the w_clk edge where any in_valid bit is high.
  - Winner is the first valid requester searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Registers grant, cur_src and busy=1; sets rr_ptr=winner.
  - Arbitration latency: 1 cycle from valid to first possible transfer. No transfer occurs in IDLE.
- LOCK transfer (combinational):
  - in_ready[g] = !full.
  - w_en = in_valid[g] & !full.
  - w_data = in_data slice g.
  - in_ready of non-owners = 0.
  - A beat transfers when in_valid[g] & in_ready[g].
- beat_cnt:
  - Increments on each transfer and resets to 0 on release.
  - Width is clog2(MAX_BURST)+1.
- Release (LOCK -> IDLE at the edge of a transfer):
  - Occurs when in_last[g]=1, or when beat_cnt==MAX_BURST-1.
  - grant, cur_src and busy clear next cycle.
  - One mandatory idle cycle separates grants.
- Forced release at MAX_BURST:
  - Requester is not notified.
  - It re-arbitrates normally; the remainder of its packet follows a later grant, possibly after other sources' packets.
- full high in LOCK:
  - w_en=0 and in_ready=0; grant and beat_cnt held.
  - Resumes the cycle after full deasserts.
  - w_en is never asserted while full=1.
- Owner drops in_valid mid-packet:
  - Grant held indefinitely and w_en=0.
  - Other requesters wait; no timeout.
- Simultaneous release and new requests:
  - Requests are not serviced in the release cycle.
  - Next IDLE cycle arbitrates with the updated rr_ptr, so the just-served requester has lowest priority.
- Single requester: re-granted after each one-cycle IDLE gap.
- Reset mid-packet: partially written beats remain in the FIFO; the arbiter returns to IDLE with rr_ptr at its reset value.
- in_last on a non-transfer cycle (valid low or full high) has no effect.

Test Plan:
1. Reset, then req0 sends 3 beats (0xA1, 0xA2, 0xA3 with last), full=0 -> grant=0001 one cycle after valid; w_en high 3 consecutive cycles with those data; grant=0 on the next cycle.
2. req1 and req3 both valid with 2-beat packets at once after reset (rr_ptr=3) -> req0 would have priority but is idle, so req1 served first, one IDLE cycle, then req3; never interleaved; cur_src goes 1 then 3.
3. req2 mid 4-beat packet, full forced high for 3 cycles after beat 2 -> w_en=0 and in_ready[2]=0 during full; grant stays 0100; beats 3-4 written after full drops; total w_en count = 4.
4. MAX_BURST=16, req0 sends a 20-beat packet while req1 is waiting -> release after beat 16 with no last; req1 granted next; req0's remaining 4 beats follow req1's packet.
5. Assert w_rst low while req1 is at beat 2 of 5 -> w_en, grant, busy and in_ready go 0 immediately; after release, req1 and req2 valid -> req1 wins (rr_ptr reset to 3).
6. Owner req0 drops valid for 5 cycles mid-packet while req1 is valid -> w_en=0, grant stays 0001, in_ready[1]=0 throughout; packet completes when req0 resumes.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-aware arbiter in front of the async FIFO write port.
// A grant is held for a whole packet (or up to MAX_BURST beats), so packets
// from different sources never interleave in the FIFO.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ-1:0]            in_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQ-1:0]            in_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [ID_WIDTH-1:0]           cur_src,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_WIDTH-1:0] cur_src_q, cur_src_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  xfer;
  logic                  release_now;

  // State register; reset takes effect without waiting for a clock edge.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      cur_src_q  <= '0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cur_src_q  <= cur_src_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  always_comb begin
    logic [IDX_W-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && in_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_WIDTH'(idx);
      end
    end
  end

  // Select the owner's valid/last/data using the one-hot grant.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own_valid = in_valid[i];
        own_last  = in_last[i];
        own_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign xfer        = (state_q == LOCK) && own_valid && !full;
  assign release_now = xfer && (own_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

  // Next-state: grab in IDLE, count beats in LOCK, drop on last or burst limit.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cur_src_d  = cur_src_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = LOCK;
          grant_d    = NUM_REQ'(1) << win_idx;
          cur_src_d  = win_idx;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
          rr_ptr_d   = win_idx;
        end
      end
      LOCK: begin
        if (release_now) begin
          state_d    = IDLE;
          grant_d    = '0;
          cur_src_d  = '0;
          busy_d     = 1'b0;
          beat_cnt_d = '0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: the write port is only ever opened to the owner while not full.
  always_comb begin
    in_ready = '0;
    w_en     = 1'b0;
    w_data   = '0;
    if (state_q == LOCK) begin
      in_ready = grant_q & {NUM_REQ{!full}};
      w_en     = own_valid && !full;
      w_data   = own_data;
    end
  end

  assign grant   = grant_q;
  assign cur_src = cur_src_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a write-side scoreboard.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic           w_clk = 1'b0;
  logic           w_rst = 1'b0;
  logic [NR-1:0]  in_valid = '0;
  logic [NR-1:0]  in_last = '0;
  logic [NR*DW-1:0] in_data = '0;
  logic [NR-1:0]  in_ready;
  logic           full = 1'b0;
  logic           w_en;
  logic [DW-1:0]  w_data;
  logic [NR-1:0]  grant;
  logic [1:0]     cur_src;
  logic           busy;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(16), .ID_WIDTH(2)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(in_ready), .full(full), .w_en(w_en),
    .w_data(w_data), .grant(grant), .cur_src(cur_src), .busy(busy)
  );

  always #5 w_clk = ~w_clk;

  // Per-requester pending beats {last, data}; expected FIFO writes {src, data}.
  logic [8:0] src_q [NR][$];
  logic [9:0] exp_q [$];
  int         wen_cyc [$];
  int         cyc = 0;
  logic [NR-1:0] hold = '0;
  logic       full_r = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int src, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) src_q[src].push_back({(i == n - 1), base + 8'(i)});
  endtask

  task automatic expect_beats(input int src, input logic [7:0] base, input int first, input int n);
    for (int i = first; i < first + n; i++) exp_q.push_back({2'(src), base + 8'(i)});
  endtask

  function automatic bit all_empty();
    bit e = (exp_q.size() == 0);
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0 && !hold[i]) begin
        in_valid[i] = 1'b1;
        in_last[i]  = src_q[i][0][8];
        in_data[i*DW +: DW] = src_q[i][0][7:0];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        in_data[i*DW +: DW] = '0;
      end
    end
    full = full_r;
  endtask

  task automatic sample();
    logic [9:0] e;
    cyc++;
    if (w_en) begin
      wen_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_wen", 32'(w_data), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        $display("write: cycle=%0d src=%0d data=0x%0h", cyc, cur_src, w_data);
        chk("w_data", 32'(w_data), 32'(e[7:0]));
        chk("w_src", 32'(cur_src), 32'(e[9:8]));
      end
    end
    if (full) chk("wen_while_full", 32'(w_en), 0);
    if (busy) chk("ready_nonowner", 32'(in_ready & ~grant), 0);
    for (int i = 0; i < NR; i++)
      if (in_valid[i] && in_ready[i]) void'(src_q[i].pop_front());
  endtask

  task automatic tick();
    @(posedge w_clk); #1; drive();
    @(negedge w_clk); sample();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!all_empty() && n < 400) begin tick(); n++; end
    chk({tag, "_drain"}, 32'(all_empty()), 1);
    repeat (2) tick();
    chk({tag, "_idle"}, 32'({busy, grant}), 0);
  endtask

  task automatic do_reset();
    w_rst  = 1'b0;
    hold   = '0;
    full_r = 1'b0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    #1; drive();
    repeat (2) @(negedge w_clk);
    @(posedge w_clk); #1; w_rst = 1'b1;
    @(negedge w_clk);
    wen_cyc.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, even with every requester asserting valid.
    in_valid = '1;
    full = 1'b0;
    #12;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cur_src", 32'(cur_src), 0);
    chk("rst_wen", 32'(w_en), 0);
    chk("rst_wdata", 32'(w_data), 0);
    chk("rst_ready", 32'(in_ready), 0);
    do_reset();

    // 1: single 3-beat packet from req0.
    load(0, 3, 8'hA1); expect_beats(0, 8'hA1, 0, 3);
    tick();
    chk("t1_idle_grant", 32'(grant), 0);
    chk("t1_idle_wen", 32'(w_en), 0);
    tick();
    chk("t1_grant", 32'(grant), 32'b0001);
    chk("t1_busy", 32'(busy), 1);
    tick(); tick(); tick();
    chk("t1_release", 32'({busy, grant}), 0);
    chk("t1_count", 32'(wen_cyc.size()), 3);
    if (wen_cyc.size() == 3) chk("t1_back2back", 32'(wen_cyc[2] - wen_cyc[0]), 2);
    chk("t1_exp_empty", 32'(exp_q.size()), 0);

    // 2: req1 and req3 together; req1 first, then one idle cycle, then req3.
    do_reset();
    load(1, 2, 8'hB1); load(3, 2, 8'hC1);
    expect_beats(1, 8'hB1, 0, 2); expect_beats(3, 8'hC1, 0, 2);
    drain("t2");
    chk("t2_count", 32'(wen_cyc.size()), 4);
    if (wen_cyc.size() == 4) chk("t2_gap", 32'(wen_cyc[2] - wen_cyc[1]), 2);

    // 3: full held high for 3 cycles after beat 2 of req2.
    do_reset();
    load(2, 4, 8'hD1); expect_beats(2, 8'hD1, 0, 4);
    tick(); tick(); tick();
    full_r = 1'b1;
    repeat (3) begin
      tick();
      chk("t3_wen", 32'(w_en), 0);
      chk("t3_ready", 32'(in_ready[2]), 0);
      chk("t3_grant", 32'(grant), 32'b0100);
    end
    full_r = 1'b0;
    drain("t3");
    chk("t3_count", 32'(wen_cyc.size()), 4);

    // 4: 20-beat packet from req0 is cut at 16; req1 slips in between.
    do_reset();
    load(0, 20, 8'h40); load(1, 2, 8'hF0);
    expect_beats(0, 8'h40, 0, 16); expect_beats(1, 8'hF0, 0, 2); expect_beats(0, 8'h40, 16, 4);
    drain("t4");
    chk("t4_count", 32'(wen_cyc.size()), 22);
    if (wen_cyc.size() == 22) chk("t4_forced_gap", 32'(wen_cyc[16] - wen_cyc[15]), 2);

    // 5: asynchronous reset while req1 presents its third beat.
    do_reset();
    load(1, 5, 8'h61); expect_beats(1, 8'h61, 0, 5);
    tick(); tick(); tick();
    @(posedge w_clk); #1; drive();
    #2;
    chk("t5_pre_wen", 32'(w_en), 1);
    w_rst = 1'b0;
    #1;
    chk("t5_rst_wen", 32'(w_en), 0);
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(in_ready), 0);
    do_reset();
    load(1, 2, 8'h71); load(2, 2, 8'h81);
    expect_beats(1, 8'h71, 0, 2); expect_beats(2, 8'h81, 0, 2);
    drain("t5");
    chk("t5_count", 32'(wen_cyc.size()), 4);

    // 6: owner req0 stalls its valid for 5 cycles mid-packet.
    do_reset();
    load(0, 4, 8'h91); load(1, 2, 8'hE1);
    expect_beats(0, 8'h91, 0, 4); expect_beats(1, 8'hE1, 0, 2);
    tick(); tick(); tick();
    hold[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("t6_wen", 32'(w_en), 0);
      chk("t6_grant", 32'(grant), 32'b0001);
      chk("t6_ready1", 32'(in_ready[1]), 0);
    end
    hold[0] = 1'b0;
    drain("t6");
    chk("t6_count", 32'(wen_cyc.size()), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
